soc_system_led_pio: RTL and testbench

SOC_SYSTEM_LED_PIO -- requirements
Module: soc_system_led_pio

---
 rtl/soc_system_led_pio.sv | 118 +++++++++++
 tb/tb_soc_system_led_pio.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_led_pio.sv
// Avalon-MM LED PIO: DATA/SET/CLEAR register bank with per-bit blink and a
// global 8-bit PWM brightness stage feeding a registered LED drive.
module soc_system_led_pio #(
  parameter int unsigned WIDTH       = 10,
  parameter logic [31:0] RESET_VALUE = 32'd0,
  parameter int unsigned PRESCALE_W  = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam int unsigned PWM_W = 8;
  localparam logic [WIDTH-1:0] RST_DATA = RESET_VALUE[WIDTH-1:0];

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_BLINK  = 3'd3;
  localparam logic [2:0] ADDR_PERIOD = 3'd4;
  localparam logic [2:0] ADDR_DUTY   = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;

  logic [WIDTH-1:0]      data_q;
  logic [WIDTH-1:0]      blink_en_q;
  logic [PRESCALE_W-1:0] period_q;
  logic [PWM_W-1:0]      duty_q;
  logic [PRESCALE_W-1:0] cnt_q;
  logic [PWM_W-1:0]      pcnt_q;
  logic                  phase_q;

  logic                  wr_c;
  logic [WIDTH-1:0]      wdata_c;
  logic                  pwm_on_c;
  logic [WIDTH-1:0]      blink_off_c;
  logic                  unused_wdata_c;

  assign wr_c           = chipselect & ~write_n;
  assign wdata_c        = writedata[WIDTH-1:0];
  assign unused_wdata_c = ^writedata;

  assign pwm_on_c    = (pcnt_q < duty_q) || (duty_q == {PWM_W{1'b1}});
  // Bits with blink enabled are suppressed while the blink phase is low.
  assign blink_off_c = blink_en_q & ~{WIDTH{phase_q}};

  // Register bank writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RST_DATA;
      blink_en_q <= '0;
      period_q   <= '1;
      duty_q     <= '1;
    end else if (wr_c) begin
      case (address)
        ADDR_DATA:   data_q     <= wdata_c;
        ADDR_SET:    data_q     <= data_q | wdata_c;
        ADDR_CLEAR:  data_q     <= data_q & ~wdata_c;
        ADDR_BLINK:  blink_en_q <= wdata_c;
        ADDR_PERIOD: period_q   <= writedata[PRESCALE_W-1:0];
        ADDR_DUTY:   duty_q     <= writedata[PWM_W-1:0];
        default:     ;
      endcase
    end
  end

  // Blink prescaler; a PERIOD write restarts the half-period with phase high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else if (wr_c && (address == ADDR_PERIOD)) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else if (cnt_q == period_q) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + PRESCALE_W'(1);
    end
  end

  // Free-running PWM counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + PWM_W'(1);
    end
  end

  // LED drive from pre-edge register state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= RST_DATA;
    end else begin
      out_port <= data_q & ~blink_off_c & {WIDTH{pwm_on_c}};
    end
  end

  // Combinational read mux; write-only and unused addresses read as zero
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata = 32'(data_q);
      ADDR_BLINK:  readdata = 32'(blink_en_q);
      ADDR_PERIOD: readdata = 32'(period_q);
      ADDR_DUTY:   readdata = 32'(duty_q);
      ADDR_STATUS: readdata = {16'd0, pcnt_q, 7'd0, phase_q};
      default:     readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_soc_system_led_pio.sv
// Bench for soc_system_led_pio: a cycle model predicts out_port into a queue,
// popped each falling edge; directed register reads and pattern counts on top.
module tb_soc_system_led_pio;

  localparam int unsigned W = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;

  int n_checks = 0;
  int n_errors = 0;

  soc_system_led_pio #(.WIDTH(W), .RESET_VALUE(32'd0), .PRESCALE_W(24)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [W-1:0]  m_data, m_blink, m_exp;
  logic [23:0]   m_period, m_cnt;
  logic [7:0]    m_duty, m_pcnt;
  logic          m_phase, m_pwm, m_wr;
  logic [W-1:0]  exp_q[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data = '0; m_blink = '0; m_period = 24'hFFFFFF; m_duty = 8'hFF;
      m_cnt = '0; m_pcnt = '0; m_phase = 1'b1;
      exp_q.delete();
    end else begin
      m_pwm = (m_duty == 8'hFF) || (m_pcnt < m_duty);
      m_exp = '0;
      for (int i = 0; i < W; i++)
        m_exp[i] = m_data[i] && m_pwm && (!m_blink[i] || m_phase);
      exp_q.push_back(m_exp);
      m_wr = chipselect && !write_n;
      m_pcnt = m_pcnt + 8'd1;
      if (m_wr && address == 3'd4) begin
        m_cnt = '0; m_phase = 1'b1;
      end else if (m_cnt == m_period) begin
        m_cnt = '0; m_phase = !m_phase;
      end else begin
        m_cnt = m_cnt + 24'd1;
      end
      if (m_wr) begin
        case (address)
          3'd0: m_data = writedata[W-1:0];
          3'd1: m_data = m_data | writedata[W-1:0];
          3'd2: m_data = m_data & ~writedata[W-1:0];
          3'd3: m_blink = writedata[W-1:0];
          3'd4: m_period = writedata[23:0];
          3'd5: m_duty = writedata[7:0];
          default: ;
        endcase
      end
    end
  end

  logic [W-1:0] popped;
  always @(negedge clk) begin
    if (reset_n && exp_q.size() > 0) begin
      popped = exp_q.pop_front();
      check("out_model", 32'(out_port), 32'(popped));
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1 check(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  int ones, others;
  logic [7:0] blink_pat;

  task automatic blink_window(input string tag);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      blink_pat[7-k] = out_port[0];
      check({tag, "_hi"}, 32'(out_port[W-1:1]), 32'h1FF);
    end
    check(tag, 32'(blink_pat), 32'h000000F0);
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    #1 check("rst_out", 32'(out_port), 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rd("rst_data", 3'd0, 32'h0);
    rd("rst_duty", 3'd5, 32'hFF);
    rd("rst_period", 3'd4, 32'hFFFFFF);
    rd("rst_blink", 3'd3, 32'h0);
    check("rst_out2", 32'(out_port), 32'h0);

    // DATA / SET / CLEAR with out-of-width bits
    wr(3'd0, 32'hFFFFF3FF);
    wr(3'd1, 32'h00000C00);
    wr(3'd2, 32'h00000003);
    @(negedge clk);
    check("setclr_out", 32'(out_port), 32'h3FC);
    rd("data_rb", 3'd0, 32'h3FC);
    rd("set_rd0", 3'd1, 32'h0);
    rd("clr_rd0", 3'd2, 32'h0);

    // Blink with half-period 4 cycles, then mid-count restart
    wr(3'd0, 32'h3FF);
    wr(3'd3, 32'h001);
    wr(3'd4, 32'd3);
    blink_window("blink");
    repeat (2) @(negedge clk);
    wr(3'd4, 32'd3);
    blink_window("blink_restart");
    rd("period_rb", 3'd4, 32'd3);
    rd("blink_rb", 3'd3, 32'h1);

    // PWM brightness
    wr(3'd3, 32'h0);
    wr(3'd5, 32'd64);
    ones = 0; others = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (out_port == 10'h3FF) ones++;
      else if (out_port != 10'h000) others++;
    end
    check("pwm64_on", 32'(ones), 32'd64);
    check("pwm64_other", 32'(others), 32'd0);
    wr(3'd5, 32'd0);
    @(negedge clk);
    ones = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (out_port != 10'h000) ones++;
    end
    check("pwm0_nonzero", 32'(ones), 32'd0);
    wr(3'd5, 32'h1FF);
    @(negedge clk);
    ones = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (out_port == 10'h3FF) ones++;
    end
    check("pwm255_on", 32'(ones), 32'd64);
    rd("duty_rb", 3'd5, 32'hFF);

    // Unselected write and unmapped address
    @(negedge clk);
    address = 3'd0; chipselect = 1'b0; write_n = 1'b0; writedata = 32'h0;
    @(negedge clk);
    write_n = 1'b1;
    rd("cs0_data", 3'd0, 32'h3FF);
    rd("addr7", 3'd7, 32'h0);

    // Asynchronous reset mid-blink
    wr(3'd0, 32'h155);
    wr(3'd3, 32'h155);
    wr(3'd4, 32'd2);
    repeat (5) @(negedge clk);
    address = 3'd6;
    #3 reset_n = 1'b0;
    #1 check("async_rst_out", 32'(out_port), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("status_after_rst", readdata, 32'h1);
    rd("data_after_rst", 3'd0, 32'h0);
    rd("period_after_rst", 3'd4, 32'hFFFFFF);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
